// File: rtl/regfile_pkg.sv
// Shared defaults and types for the integer register file and its busy scoreboard.
package regfile_pkg;
    localparam int unsigned DEF_WIDTH = 64;
    localparam int unsigned DEF_DEPTH = 5;

    typedef logic [DEF_DEPTH-1:0] regAddr_t;
    typedef logic [DEF_WIDTH-1:0] regData_t;

    localparam regAddr_t ZERO_REG = '0;
endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: write->read bypass priority mux plus busy lookup.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned DEPTH  = DEF_DEPTH,
    parameter int unsigned NWRITE = 2
) (
    input  logic [DEPTH-1:0]              addr,
    input  logic [WIDTH-1:0]              stored_data,
    input  logic [2**DEPTH-1:0]           busy_vec,
    input  logic [NWRITE-1:0]             reg_write,
    input  logic [NWRITE-1:0][DEPTH-1:0]  write_reg,
    input  logic [NWRITE-1:0][WIDTH-1:0]  write_data,
    input  logic                          issue_en,
    input  logic [DEPTH-1:0]              issue_reg,
    output logic [WIDTH-1:0]              data,
    output logic                          busy
);

    logic hit;

    always_comb begin
        hit  = 1'b0;
        data = stored_data;
        busy = 1'b0;
        // Ascending scan so the youngest (highest-index) writer wins.
        for (int w = 0; w < NWRITE; w++) begin
            if (reg_write[w] && write_reg[w] == addr) begin
                hit  = 1'b1;
                data = write_data[w];
            end
        end
        if (addr == DEPTH'(ZERO_REG)) begin
            data = '0;
            busy = 1'b0;
        end else if (hit && !(issue_en && issue_reg == addr)) begin
            busy = 1'b0;
        end else begin
            busy = busy_vec[addr];
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-port integer register file with hardwired x0, same-cycle bypass and a
// per-register busy scoreboard for decode-stage hazard detection.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned DEPTH  = DEF_DEPTH,
    parameter int unsigned NREAD  = 2,
    parameter int unsigned NWRITE = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NREAD-1:0][DEPTH-1:0]   readReg,
    output logic [NREAD-1:0][WIDTH-1:0]   readData,
    output logic [NREAD-1:0]              readBusy,
    input  logic [NWRITE-1:0]             regWrite,
    input  logic [NWRITE-1:0][DEPTH-1:0]  writeReg,
    input  logic [NWRITE-1:0][WIDTH-1:0]  dataWrite,
    input  logic                          issueEn,
    input  logic [DEPTH-1:0]              issueReg,
    output logic [DEPTH:0]                busyCount
);

    localparam int unsigned NREGS = 2**DEPTH;

    logic [WIDTH-1:0] ram_q [NREGS];
    logic [NREGS-1:0] busy_q, busy_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                ram_q[i] <= '0;
            end
        end else begin
            // Later non-blocking assignments win, giving the highest port priority.
            for (int w = 0; w < NWRITE; w++) begin
                if (regWrite[w] && writeReg[w] != DEPTH'(ZERO_REG)) begin
                    ram_q[writeReg[w]] <= dataWrite[w];
                end
            end
        end
    end

    always_comb begin
        busy_d = busy_q;
        for (int i = 1; i < NREGS; i++) begin
            for (int w = 0; w < NWRITE; w++) begin
                if (regWrite[w] && writeReg[w] == DEPTH'(i)) begin
                    busy_d[i] = 1'b0;
                end
            end
            if (issueEn && issueReg == DEPTH'(i)) begin
                busy_d[i] = 1'b1;
            end
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    always_comb begin
        busyCount = '0;
        for (int i = 0; i < NREGS; i++) begin
            busyCount = busyCount + (DEPTH+1)'(busy_q[i]);
        end
    end

    for (genvar r = 0; r < NREAD; r++) begin : g_read
        regfile_read_port #(
            .WIDTH  (WIDTH),
            .DEPTH  (DEPTH),
            .NWRITE (NWRITE)
        ) u_read_port (
            .addr        (readReg[r]),
            .stored_data (ram_q[readReg[r]]),
            .busy_vec    (busy_q),
            .reg_write   (regWrite),
            .write_reg   (writeReg),
            .write_data  (dataWrite),
            .issue_en    (issueEn),
            .issue_reg   (issueReg),
            .data        (readData[r]),
            .busy        (readBusy[r])
        );
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: expected values queued at stimulus, popped at check.
module tb_regfile_scoreboard;

    logic             clk;
    logic             rst_n;
    logic [1:0][4:0]  readReg;
    logic [1:0][63:0] readData;
    logic [1:0]       readBusy;
    logic [1:0]       regWrite;
    logic [1:0][4:0]  writeReg;
    logic [1:0][63:0] dataWrite;
    logic             issueEn;
    logic [4:0]       issueReg;
    logic [5:0]       busyCount;

    int vectors;
    int miscompares;
    logic [63:0] exp_q[$];
    logic [63:0] mdl [32];

    regfile_scoreboard dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .readReg   (readReg),
        .readData  (readData),
        .readBusy  (readBusy),
        .regWrite  (regWrite),
        .writeReg  (writeReg),
        .dataWrite (dataWrite),
        .issueEn   (issueEn),
        .issueReg  (issueReg),
        .busyCount (busyCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        regWrite  = '0;
        writeReg  = '0;
        dataWrite = '0;
        issueEn   = 1'b0;
        issueReg  = '0;
    endtask

    task automatic pulse_reset();
        #2;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [63:0] e;
        for (int i = 1; i < 32; i += 2) begin
            regWrite  = 2'b11;
            writeReg  = '{5'(i + 1), 5'(i)};
            dataWrite = '{64'hA5, 64'hA5};
            issueEn   = 1'b1;
            issueReg  = 5'(i);
            tick();
        end
        idle();
        #1;
        if (busyCount !== 6'd0) begin
            exp_q.push_back(64'd0);
        end
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 32; i++) begin
            readReg[0] = 5'(i);
            #1;
            exp_q.push_back(64'd0);
            e = exp_q.pop_front();
            vectors++;
            if (readData[0] !== e) begin
                miscompares++;
                $display("FAIL reset_data reg%0d got %h want %h", i, readData[0], e);
            end
        end
        exp_q.delete();
        vectors++;
        if (busyCount !== 6'd0) begin
            miscompares++;
            $display("FAIL reset_busycount got %0d want 0", busyCount);
        end
        #1;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_x0();
        logic [63:0] e;
        regWrite[0]  = 1'b1;
        writeReg[0]  = 5'd0;
        dataWrite[0] = 64'hFFFF;
        readReg[0]   = 5'd0;
        #1;
        exp_q.push_back(64'd0);
        e = exp_q.pop_front();
        vectors++;
        if (readData[0] !== e) begin
            miscompares++;
            $display("FAIL x0_same_cycle got %h want %h", readData[0], e);
        end
        tick();
        idle();
        #1;
        exp_q.push_back(64'd0);
        e = exp_q.pop_front();
        vectors++;
        if (readData[0] !== e) begin
            miscompares++;
            $display("FAIL x0_next_cycle got %h want %h", readData[0], e);
        end
    endtask

    task automatic test_bypass();
        logic [63:0] e;
        regWrite[0]  = 1'b1;
        writeReg[0]  = 5'd5;
        dataWrite[0] = 64'h1234;
        readReg[1]   = 5'd5;
        #1;
        exp_q.push_back(64'h1234);
        e = exp_q.pop_front();
        vectors++;
        if (readData[1] !== e) begin
            miscompares++;
            $display("FAIL bypass_same_cycle got %h want %h", readData[1], e);
        end
        exp_q.push_back(64'h1234);
        tick();
        idle();
        #1;
        e = exp_q.pop_front();
        vectors++;
        if (readData[1] !== e) begin
            miscompares++;
            $display("FAIL bypass_hold got %h want %h", readData[1], e);
        end
    endtask

    task automatic test_conflict();
        logic [63:0] e;
        regWrite  = 2'b11;
        writeReg  = '{5'd7, 5'd7};
        dataWrite = '{64'h22, 64'h11};
        readReg[0] = 5'd7;
        #1;
        exp_q.push_back(64'h22);
        e = exp_q.pop_front();
        vectors++;
        if (readData[0] !== e) begin
            miscompares++;
            $display("FAIL conflict_bypass got %h want %h", readData[0], e);
        end
        exp_q.push_back(64'h22);
        tick();
        idle();
        #1;
        e = exp_q.pop_front();
        vectors++;
        if (readData[0] !== e) begin
            miscompares++;
            $display("FAIL conflict_stored got %h want %h", readData[0], e);
        end
    endtask

    task automatic test_scoreboard();
        issueEn    = 1'b1;
        issueReg   = 5'd9;
        readReg[0] = 5'd9;
        tick();
        idle();
        #1;
        vectors++;
        if (readBusy[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL sb_busy_after_issue got %b want 1", readBusy[0]);
        end
        vectors++;
        if (busyCount !== 6'd1) begin
            miscompares++;
            $display("FAIL sb_count_after_issue got %0d want 1", busyCount);
        end
        regWrite[1]  = 1'b1;
        writeReg[1]  = 5'd9;
        dataWrite[1] = 64'h99;
        #1;
        vectors++;
        if (readBusy[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL sb_busy_bypass_clear got %b want 0", readBusy[0]);
        end
        vectors++;
        if (busyCount !== 6'd1) begin
            miscompares++;
            $display("FAIL sb_count_not_bypassed got %0d want 1", busyCount);
        end
        tick();
        idle();
        #1;
        vectors++;
        if (busyCount !== 6'd0 || readBusy[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL sb_after_writeback count %0d busy %b want 0 0", busyCount, readBusy[0]);
        end
    endtask

    task automatic test_issue_write();
        logic [63:0] e;
        issueEn      = 1'b1;
        issueReg     = 5'd3;
        regWrite[0]  = 1'b1;
        writeReg[0]  = 5'd3;
        dataWrite[0] = 64'h55;
        readReg[1]   = 5'd3;
        exp_q.push_back(64'h55);
        tick();
        idle();
        #1;
        e = exp_q.pop_front();
        vectors++;
        if (readData[1] !== e) begin
            miscompares++;
            $display("FAIL issue_write_data got %h want %h", readData[1], e);
        end
        vectors++;
        if (readBusy[1] !== 1'b1 || busyCount !== 6'd1) begin
            miscompares++;
            $display("FAIL issue_write_busy busy %b count %0d want 1 1", readBusy[1], busyCount);
        end
        regWrite[0] = 1'b1;
        writeReg[0] = 5'd3;
        dataWrite[0] = 64'h55;
        tick();
        idle();
    endtask

    task automatic test_x0_issue();
        issueEn    = 1'b1;
        issueReg   = 5'd0;
        readReg[0] = 5'd0;
        tick();
        idle();
        #1;
        vectors++;
        if (busyCount !== 6'd0 || readBusy[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL x0_never_busy count %0d busy %b want 0 0", busyCount, readBusy[0]);
        end
    endtask

    task automatic test_midop_reset();
        logic [63:0] e;
        regWrite[0]  = 1'b1;
        writeReg[0]  = 5'd10;
        dataWrite[0] = 64'h77;
        issueEn      = 1'b1;
        issueReg     = 5'd12;
        pulse_reset();
        idle();
        readReg[0] = 5'd10;
        readReg[1] = 5'd12;
        tick();
        exp_q.push_back(64'd0);
        e = exp_q.pop_front();
        vectors++;
        if (readData[0] !== e) begin
            miscompares++;
            $display("FAIL midop_reset_write got %h want %h", readData[0], e);
        end
        vectors++;
        if (busyCount !== 6'd0 || readBusy[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL midop_reset_busy count %0d busy %b want 0 0", busyCount, readBusy[1]);
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0]  wa0, wa1, ra0, ra1;
        logic [63:0] d0, d1, e0, e1, e;
        pulse_reset();
        for (int i = 0; i < 32; i++) mdl[i] = '0;
        for (int n = 0; n < 40; n++) begin
            wa0 = 5'($urandom_range(0, 31));
            wa1 = (n % 4 == 0) ? wa0 : 5'($urandom_range(0, 31));
            d0  = {$urandom, $urandom};
            d1  = {$urandom, $urandom};
            ra0 = 5'($urandom_range(0, 31));
            ra1 = (n % 3 == 0) ? wa1 : wa0;
            regWrite  = 2'($urandom_range(0, 3));
            writeReg  = '{wa1, wa0};
            dataWrite = '{d1, d0};
            readReg   = '{ra1, ra0};
            e0 = mdl[ra0];
            if (regWrite[0] && wa0 == ra0) e0 = d0;
            if (regWrite[1] && wa1 == ra0) e0 = d1;
            if (ra0 == 5'd0) e0 = '0;
            e1 = mdl[ra1];
            if (regWrite[0] && wa0 == ra1) e1 = d0;
            if (regWrite[1] && wa1 == ra1) e1 = d1;
            if (ra1 == 5'd0) e1 = '0;
            exp_q.push_back(e0);
            exp_q.push_back(e1);
            #1;
            e = exp_q.pop_front();
            vectors++;
            if (readData[0] !== e) begin
                miscompares++;
                $display("FAIL b2b_port0 iter%0d reg%0d got %h want %h", n, ra0, readData[0], e);
            end
            e = exp_q.pop_front();
            vectors++;
            if (readData[1] !== e) begin
                miscompares++;
                $display("FAIL b2b_port1 iter%0d reg%0d got %h want %h", n, ra1, readData[1], e);
            end
            if (regWrite[0] && wa0 != 5'd0) mdl[wa0] = d0;
            if (regWrite[1] && wa1 != 5'd0) mdl[wa1] = d1;
            tick();
        end
        idle();
        for (int i = 0; i < 32; i++) begin
            readReg[0] = 5'(i);
            #1;
            exp_q.push_back(mdl[i]);
            e = exp_q.pop_front();
            vectors++;
            if (readData[0] !== e) begin
                miscompares++;
                $display("FAIL b2b_final reg%0d got %h want %h", i, readData[0], e);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        readReg     = '0;
        idle();
        #12;
        rst_n = 1'b1;
        tick();
        test_reset();
        test_x0();
        test_bypass();
        test_conflict();
        test_scoreboard();
        test_issue_write();
        test_x0_issue();
        test_midop_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
